// File: rtl/data_memory.sv
// Word-organised data memory with byte-lane load/store and sticky fault capture.
// Define DMEM_RESET_CLEAR_EN to have the asynchronous reset clear the whole array.
module data_memory #(
    parameter int DEPTH_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  Funct3,
    output logic [31:0] ReadData,
    output logic        Misaligned,
    output logic        AccessFault,
    output logic        ErrSticky,
    output logic [31:0] ErrAddr
);

    localparam int          AW       = $clog2(DEPTH_WORDS);
    localparam logic [32:0] BYTE_CAP = 33'(DEPTH_WORDS) * 33'd4;

    logic [31:0]   mem [DEPTH_WORDS];

    logic          active;
    logic          out_of_range;
    logic          store_legal;
    logic          load_legal;
    logic          funct_illegal;
    logic          align_bad;
    logic          fault;
    logic          store_en;
    logic [AW-1:0] word_idx;
    logic [1:0]    offset;
    logic [31:0]   cur_word;
    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;
    logic [31:0]   load_val;
    logic [31:0]   lane_data;
    logic [3:0]    byte_en;

    assign active       = MemRead | MemWrite;
    assign word_idx     = Address[AW+1:2];
    assign offset       = Address[1:0];
    assign out_of_range = {1'b0, Address} >= BYTE_CAP;
    assign cur_word     = mem[word_idx];

    // When a store is present its legality rules win, even for a combined read+write.
    always_comb begin
        store_legal   = Funct3 inside {3'b000, 3'b001, 3'b010};
        load_legal    = store_legal | (Funct3 inside {3'b100, 3'b101});
        funct_illegal = MemWrite ? !store_legal : !load_legal;
        align_bad     = 1'b0;
        case (Funct3)
            3'b001, 3'b101: align_bad = Address[0];
            3'b010:         align_bad = |Address[1:0];
            default:        align_bad = 1'b0;
        endcase
    end

    assign Misaligned  = active & align_bad;
    assign AccessFault = active & (out_of_range | funct_illegal);
    assign fault       = Misaligned | AccessFault;

    always_comb begin
        byte_sel = cur_word[{offset, 3'b000} +: 8];
        half_sel = Address[1] ? cur_word[31:16] : cur_word[15:0];
        load_val = '0;
        case (Funct3)
            3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  load_val = {24'b0, byte_sel};
            3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
            3'b101:  load_val = {16'b0, half_sel};
            3'b010:  load_val = cur_word;
            default: load_val = '0;
        endcase
        ReadData = (MemRead && !fault) ? load_val : 32'h0;
    end

    // Store data is replicated across lanes so the byte enables alone pick the target.
    always_comb begin
        byte_en   = 4'b0000;
        lane_data = '0;
        case (Funct3[1:0])
            2'b00: begin
                byte_en   = 4'b0001 << offset;
                lane_data = {4{WriteData[7:0]}};
            end
            2'b01: begin
                byte_en   = Address[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{WriteData[15:0]}};
            end
            2'b10: begin
                byte_en   = 4'b1111;
                lane_data = WriteData;
            end
            default: begin
                byte_en   = 4'b0000;
                lane_data = '0;
            end
        endcase
    end

    assign store_en = MemWrite & !fault;

`ifdef DMEM_RESET_CLEAR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem[i] <= '0;
            end
        end else if (store_en) begin
            for (int l = 0; l < 4; l++) begin
                if (byte_en[l]) begin
                    mem[word_idx][8*l +: 8] <= lane_data[8*l +: 8];
                end
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst_n && store_en) begin
            for (int l = 0; l < 4; l++) begin
                if (byte_en[l]) begin
                    mem[word_idx][8*l +: 8] <= lane_data[8*l +: 8];
                end
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ErrSticky <= 1'b0;
            ErrAddr   <= '0;
        end else if (active && fault && !ErrSticky) begin
            ErrSticky <= 1'b1;
            ErrAddr   <= Address;
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// Directed-vector bench for data_memory with hand-computed expected values.
module tb_data_memory;

    logic        clk;
    logic        rst_n;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        MemRead;
    logic        MemWrite;
    logic [2:0]  Funct3;
    logic [31:0] ReadData;
    logic        Misaligned;
    logic        AccessFault;
    logic        ErrSticky;
    logic [31:0] ErrAddr;

    int vector_count = 0;
    int miss_count   = 0;

    localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010,
                           F_BU = 3'b100, F_HU = 3'b101;

    data_memory #(.DEPTH_WORDS(256)) dut (
        .clk(clk), .rst_n(rst_n), .Address(Address), .WriteData(WriteData),
        .MemRead(MemRead), .MemWrite(MemWrite), .Funct3(Funct3),
        .ReadData(ReadData), .Misaligned(Misaligned), .AccessFault(AccessFault),
        .ErrSticky(ErrSticky), .ErrAddr(ErrAddr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        vector_count++;
        if (actual !== expected) begin
            miss_count++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    // Drives one request after the falling edge; it commits at the following rising edge.
    task automatic applyStimulus(input logic rd, input logic wr, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        MemRead   = rd;
        MemWrite  = wr;
        Funct3    = f3;
        Address   = addr;
        WriteData = wdata;
        #1;
    endtask

    initial begin
        rst_n = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        Funct3 = F_W; Address = '0; WriteData = '0;
        #2;
        checkOutput("rst_sticky", {31'b0, ErrSticky}, 32'd0);
        checkOutput("rst_addr", ErrAddr, 32'h0);
        #10 rst_n = 1'b1;

        applyStimulus(1, 0, F_W, 32'h00, 0);
        checkOutput("lw0_mis", {31'b0, Misaligned}, 32'd0);
        checkOutput("lw0_fault", {31'b0, AccessFault}, 32'd0);
`ifdef DMEM_RESET_CLEAR_EN
        checkOutput("lw0_data", ReadData, 32'h0);
`endif

        applyStimulus(0, 1, F_W, 32'h10, 32'hDEADBEEF);
        checkOutput("sw10_fault", {31'b0, AccessFault}, 32'd0);
        applyStimulus(1, 0, F_B, 32'h11, 0);
        checkOutput("lb11", ReadData, 32'hFFFFFFBE);
        applyStimulus(1, 0, F_BU, 32'h13, 0);
        checkOutput("lbu13", ReadData, 32'h000000DE);
        applyStimulus(1, 0, F_H, 32'h12, 0);
        checkOutput("lh12", ReadData, 32'hFFFFDEAD);
        applyStimulus(1, 0, F_HU, 32'h10, 0);
        checkOutput("lhu10", ReadData, 32'h0000BEEF);

        applyStimulus(0, 1, F_B, 32'h12, 32'h00000055);
        applyStimulus(1, 0, F_W, 32'h10, 0);
        checkOutput("sb_lw10", ReadData, 32'hDE55BEEF);
        applyStimulus(0, 1, F_H, 32'h10, 32'h00001234);
        applyStimulus(1, 0, F_W, 32'h10, 0);
        checkOutput("sh_lw10", ReadData, 32'hDE551234);

        applyStimulus(0, 1, F_W, 32'h12, 32'h99999999);
        checkOutput("sw12_mis", {31'b0, Misaligned}, 32'd1);
        checkOutput("sw12_fault", {31'b0, AccessFault}, 32'd0);
        checkOutput("sw12_sticky_pre", {31'b0, ErrSticky}, 32'd0);
        applyStimulus(1, 0, F_W, 32'h10, 0);
        checkOutput("sw12_unchanged", ReadData, 32'hDE551234);
        checkOutput("sticky_set", {31'b0, ErrSticky}, 32'd1);
        checkOutput("erraddr_12", ErrAddr, 32'h12);

        applyStimulus(1, 0, F_W, 32'h400, 0);
        checkOutput("lw400_fault", {31'b0, AccessFault}, 32'd1);
        checkOutput("lw400_mis", {31'b0, Misaligned}, 32'd0);
        checkOutput("lw400_data", ReadData, 32'h0);
        applyStimulus(0, 0, F_W, 32'h10, 0);
        checkOutput("erraddr_kept", ErrAddr, 32'h12);
        checkOutput("idle_data", ReadData, 32'h0);

        applyStimulus(1, 0, 3'b011, 32'h10, 0);
        checkOutput("ld011_fault", {31'b0, AccessFault}, 32'd1);
        checkOutput("ld011_data", ReadData, 32'h0);
        applyStimulus(0, 1, F_BU, 32'h10, 32'h000000AA);
        checkOutput("sbu_fault", {31'b0, AccessFault}, 32'd1);
        applyStimulus(1, 0, F_W, 32'h10, 0);
        checkOutput("sbu_dropped", ReadData, 32'hDE551234);

        applyStimulus(0, 1, F_W, 32'h20, 32'h11111111);
        applyStimulus(1, 1, F_W, 32'h20, 32'hCAFEF00D);
        checkOutput("rw_old", ReadData, 32'h11111111);
        checkOutput("rw_fault", {31'b0, AccessFault}, 32'd0);
        applyStimulus(1, 0, F_W, 32'h20, 0);
        checkOutput("rw_new", ReadData, 32'hCAFEF00D);

        applyStimulus(0, 1, F_W, 32'h3FC, 32'hA5A5A5A5);
        checkOutput("sw3fc_fault", {31'b0, AccessFault}, 32'd0);
        applyStimulus(1, 0, F_HU, 32'h3FE, 0);
        checkOutput("lhu3fe", ReadData, 32'h0000A5A5);

        // Reset between edges while a store is held across a rising edge.
        applyStimulus(0, 1, F_W, 32'h20, 32'h77777777);
        rst_n = 1'b0;
        #1;
        checkOutput("async_sticky", {31'b0, ErrSticky}, 32'd0);
        checkOutput("async_addr", ErrAddr, 32'h0);
        @(posedge clk);
        #1;
        MemWrite = 1'b0;
        #2 rst_n = 1'b1;
        applyStimulus(1, 0, F_W, 32'h20, 0);
`ifdef DMEM_RESET_CLEAR_EN
        checkOutput("rst_store_blocked", ReadData, 32'h0);
`else
        checkOutput("rst_store_blocked", ReadData, 32'hCAFEF00D);
`endif
        checkOutput("post_rst_sticky", {31'b0, ErrSticky}, 32'd0);

        applyStimulus(0, 1, F_H, 32'h21, 32'h0000BBBB);
        checkOutput("sh21_mis", {31'b0, Misaligned}, 32'd1);
        applyStimulus(0, 0, F_W, 32'h0, 0);
        checkOutput("sticky_again", {31'b0, ErrSticky}, 32'd1);
        checkOutput("erraddr_21", ErrAddr, 32'h21);

        $display("== %0d vectors applied, %0d miscompares ==", vector_count, miss_count);
        $finish;
    end

endmodule
